// File: rtl/icache_nway.sv
// rtl/icache_nway.sv - N-way set-associative instruction cache with critical-word-first fill
module icache_nway #(
  parameter int ADDRLEN   = 24,
  parameter int WAYS_LOG2 = 2,
  parameter int SETS_LOG2 = 5,
  parameter int LINE_LOG2 = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               fetch,
  input  logic [ADDRLEN-1:0] fetch_addr,
  input  logic               invalidate,
  output logic               inst_ready,
  output logic [31:0]        inst_data,
  output logic               busy,
  output logic               code_rd,
  output logic [ADDRLEN-3:0] code_addr,
  input  logic               code_valid,
  input  logic [31:0]        code_data,
  input  logic               cnt_clr,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt
);

  localparam int WAYS  = 1 << WAYS_LOG2;
  localparam int SETS  = 1 << SETS_LOG2;
  localparam int WORDS = 1 << LINE_LOG2;
  localparam int TAGW  = ADDRLEN - 2 - LINE_LOG2 - SETS_LOG2;
  localparam int WW    = (WAYS_LOG2 > 0) ? WAYS_LOG2 : 1;
  localparam int DW    = SETS_LOG2 + WAYS_LOG2 + LINE_LOG2;

  typedef enum logic [2:0] {INIT, IDLE, LOOKUP, READ, FILL, DRAIN} state_t;

  state_t               state;
  logic [WAYS-1:0]      valid [SETS];
  logic [TAGW-1:0]      tags  [SETS][WAYS];
  logic [WW-1:0]        age   [SETS][WAYS];
  logic [31:0]          mem   [1<<DW];
  logic [31:0]          mem_q;
  logic [ADDRLEN-3:0]   req_wa;
  logic [SETS_LOG2-1:0] set_ptr;
  logic [WW-1:0]        victim;
  logic [LINE_LOG2-1:0] beat;
  logic                 inv_pend;

  wire unused_addr_bits = ^fetch_addr[1:0];

  logic [SETS_LOG2-1:0] req_set;
  logic [TAGW-1:0]      req_tag;
  logic [LINE_LOG2-1:0] req_off;
  assign req_set = req_wa[SETS_LOG2+LINE_LOG2-1:LINE_LOG2];
  assign req_tag = req_wa[ADDRLEN-3 -: TAGW];
  assign req_off = req_wa[LINE_LOG2-1:0];

  logic          hit, inv_found, last_beat;
  logic [WW-1:0] hit_way, free_way, lru_way, victim_sel, upd_way, upd_age;
  logic [WW-1:0] aged [WAYS];

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    inv_found = 1'b0;
    free_way = '0;
    lru_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid[req_set][w] && tags[req_set][w] == req_tag) begin
        hit = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid[req_set][w]) begin
        inv_found = 1'b1;
        free_way = WW'(w);
      end
      if (age[req_set][w] == WW'(WAYS-1)) lru_way = WW'(w);
    end
    victim_sel = inv_found ? free_way : lru_way;
    // A completed fill ages the set exactly as a hit on the victim would
    upd_way = (state == FILL) ? victim : hit_way;
    upd_age = age[req_set][upd_way];
    for (int w = 0; w < WAYS; w++) begin
      if (WW'(w) == upd_way)             aged[w] = '0;
      else if (age[req_set][w] < upd_age) aged[w] = age[req_set][w] + 1'b1;
      else                               aged[w] = age[req_set][w];
    end
    last_beat = (state == FILL) && code_valid && (beat == LINE_LOG2'(WORDS-1));
  end

  logic [DW-1:0] rd_idx, wr_idx;
  assign rd_idx = DW'((int'(req_set) * WAYS + int'(hit_way)) * WORDS + int'(req_off));
  assign wr_idx = DW'((int'(req_set) * WAYS + int'(victim)) * WORDS + int'(code_addr[LINE_LOG2-1:0]));

  always_ff @(posedge clk) begin
    if (state == FILL && code_valid) mem[wr_idx] <= code_data;
    mem_q <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int w = 0; w < WAYS; w++) age[set_ptr][w] <= WW'(w);
    end else if ((state == LOOKUP && hit) || last_beat) begin
      for (int w = 0; w < WAYS; w++) age[req_set][w] <= aged[w];
    end else if (state == LOOKUP) begin
      tags[req_set][victim_sel] <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= INIT;
      set_ptr <= '0;
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
      inst_ready <= 1'b0;
      inst_data <= '0;
      code_rd <= 1'b0;
      code_addr <= '0;
      busy <= 1'b1;
      hit_cnt <= '0;
      miss_cnt <= '0;
      req_wa <= '0;
      victim <= '0;
      beat <= '0;
      inv_pend <= 1'b0;
    end else begin
      inst_ready <= 1'b0;
      if (invalidate && state != IDLE && state != INIT) inv_pend <= 1'b1;
      if (cnt_clr) begin
        hit_cnt <= '0;
        miss_cnt <= '0;
      end else if (state == LOOKUP) begin
        if (hit && hit_cnt != 16'hFFFF)   hit_cnt <= hit_cnt + 16'd1;
        if (!hit && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
      case (state)
        INIT: begin
          valid[set_ptr] <= '0;
          inv_pend <= 1'b0;
          if (invalidate) set_ptr <= '0;
          else if (set_ptr == SETS_LOG2'(SETS-1)) begin
            set_ptr <= '0;
            busy <= 1'b0;
            state <= IDLE;
          end else set_ptr <= set_ptr + 1'b1;
        end
        IDLE: begin
          if (invalidate || inv_pend) begin
            inv_pend <= 1'b0;
            set_ptr <= '0;
            busy <= 1'b1;
            state <= INIT;
          end else if (fetch) begin
            req_wa <= fetch_addr[ADDRLEN-1:2];
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) state <= READ;
          else begin
            victim <= victim_sel;
            valid[req_set][victim_sel] <= 1'b0;
            code_rd <= 1'b1;
            code_addr <= req_wa;
            beat <= '0;
            busy <= 1'b1;
            state <= FILL;
          end
        end
        READ: begin
          inst_ready <= 1'b1;
          inst_data <= mem_q;
          state <= IDLE;
        end
        FILL: begin
          if (code_valid) begin
            // Offset wraps within the line; the line bits never change
            code_addr[LINE_LOG2-1:0] <= code_addr[LINE_LOG2-1:0] + 1'b1;
            beat <= beat + 1'b1;
            if (code_addr[LINE_LOG2-1:0] == req_off) begin
              inst_ready <= 1'b1;
              inst_data <= code_data;
            end
            if (last_beat) begin
              code_rd <= 1'b0;
              valid[req_set][victim] <= 1'b1;
              busy <= 1'b0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

endmodule
